// File: rtl/regfl_pkg.sv
//------------------------------------------------------------------------------
// Module      : regfl_pkg
// Description : Shared constants, state encoding and slice helper for the
//               register-file burst read sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package regfl_pkg;

    localparam int W  = 64;
    localparam int N  = 8;
    localparam int AW = 3;

    typedef logic [0:0] state_t;

    localparam state_t IDLE  = 1'b0;
    localparam state_t BURST = 1'b1;

    // Register 0 sits in the MSBs of the flat bus.
    function automatic int slice_msb(input logic [AW-1:0] idx);
        return (N * W - 1) - W * int'(idx);
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfl_wsel.sv
//------------------------------------------------------------------------------
// Module      : regfl_wsel
// Description : Combinational 512->64 word selector, MSB-first register packing.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfl_wsel
    import regfl_pkg::*;
(
    input  logic [N*W-1:0] src,
    input  logic [AW-1:0]  idx,
    output logic [W-1:0]   word
);

    logic [W-1:0] w_words [N];

    for (genvar g = 0; g < N; g++) begin : g_word
        assign w_words[g] = src[slice_msb(AW'(g)) -: W];
    end

    assign word = w_words[idx];

endmodule

`default_nettype wire

// File: rtl/regfl_rdseq.sv
//------------------------------------------------------------------------------
// Module      : regfl_rdseq
// Description : Burst read sequencer streaming consecutive register-file words
//               over valid/ready, wrapping modulo 8, with a saturating burst
//               counter. Define REGFL_RDSEQ_SNAP_EN to slice every word of a
//               burst from a snapshot of rf_q taken at request acceptance.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfl_rdseq #(
    parameter int W  = 64,
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] rf_q,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [AW-1:0]  req_addr,
    input  logic [AW-1:0]  req_len,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [AW-1:0]  out_idx,
    output logic           out_last,
    output logic [15:0]    burst_cnt
);

    import regfl_pkg::*;

    state_t          r_state;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   r_rem;
    logic [W-1:0]    r_data;
    logic            r_last;
    logic [15:0]     r_burst_cnt;

    logic            w_accept;
    logic            w_hs;
    logic [AW-1:0]   w_sel_idx;
    logic [N*W-1:0]  w_src;
    logic [W-1:0]    w_word;

    assign w_accept  = (r_state == IDLE) && req_valid;
    assign w_hs      = (r_state == BURST) && out_ready;
    // In IDLE the selector looks at the requested start; in BURST at the next word.
    assign w_sel_idx = (r_state == IDLE) ? req_addr : AW'(r_idx + 1'b1);

`ifdef REGFL_RDSEQ_SNAP_EN
    logic [N*W-1:0] r_snap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap <= '0;
        end else if (w_accept) begin
            r_snap <= rf_q;
        end
    end

    // The first word is taken live because the snapshot is only being loaded.
    assign w_src = (r_state == IDLE) ? rf_q : r_snap;
`else
    assign w_src = rf_q;
`endif

    regfl_wsel u_wsel (
        .src  (w_src),
        .idx  (w_sel_idx),
        .word (w_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_rem       <= '0;
            r_data      <= '0;
            r_last      <= 1'b0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= BURST;
                        r_idx   <= req_addr;
                        r_rem   <= req_len;
                        r_data  <= w_word;
                        r_last  <= (req_len == '0);
                    end
                end
                BURST: begin
                    if (w_hs) begin
                        if (r_last) begin
                            r_state <= IDLE;
                            if (r_burst_cnt != 16'hFFFF) begin
                                r_burst_cnt <= r_burst_cnt + 16'd1;
                            end
                        end else begin
                            r_idx  <= w_sel_idx;
                            r_rem  <= r_rem - 1'b1;
                            r_data <= w_word;
                            r_last <= (r_rem == AW'(1));
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign out_valid = (r_state == BURST);
    assign out_data  = r_data;
    assign out_idx   = r_idx;
    assign out_last  = r_last;
    assign burst_cnt = r_burst_cnt;

endmodule

`default_nettype wire

// File: tb/tb_regfl_rdseq.sv
//------------------------------------------------------------------------------
// Module      : tb_regfl_rdseq
// Description : Self-checking bench for regfl_rdseq (honours REGFL_RDSEQ_SNAP_EN).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfl_rdseq;

`ifdef REGFL_RDSEQ_SNAP_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] rf_q;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [2:0]   req_addr = '0;
    logic [2:0]   req_len = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [63:0]  out_data;
    logic [2:0]   out_idx;
    logic         out_last;
    logic [15:0]  burst_cnt;

    logic [63:0]  regs [8];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  idx;
        logic [63:0] data;
        logic        last;
    } obs_t;
    obs_t seen[$];

    regfl_rdseq dut (
        .clk       (clk),
        .rst       (rst),
        .rf_q      (rf_q),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .burst_cnt (burst_cnt)
    );

    always #5 clk = ~clk;

    assign rf_q = {regs[0], regs[1], regs[2], regs[3], regs[4], regs[5], regs[6], regs[7]};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: burst position, the word each slot must carry, and the count.
    bit          m_busy = 1'b0;
    int          m_addr, m_len, m_j;
    logic [63:0] m_img [8];
    logic [63:0] m_word;
    logic [15:0] m_cnt = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_cnt  = '0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy = 1'b1;
                m_addr = int'(req_addr);
                m_len  = int'(req_len);
                m_j    = 0;
                m_img  = regs;
                m_word = regs[m_addr];
            end
        end else if (out_ready) begin
            if (m_j == m_len) begin
                m_busy = 1'b0;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end else begin
                m_j++;
                m_word = SNAP ? m_img[(m_addr + m_j) % 8] : regs[(m_addr + m_j) % 8];
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready)
            seen.push_back('{idx: out_idx, data: out_data, last: out_last});
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("req_ready", 64'(req_ready), 64'(!m_busy));
            chk("out_valid", 64'(out_valid), 64'(m_busy));
            chk("burst_cnt", 64'(burst_cnt), 64'(m_cnt));
            if (m_busy) begin
                chk("out_idx",  64'(out_idx),  64'((m_addr + m_j) % 8));
                chk("out_last", 64'(out_last), 64'(m_j == m_len));
                chk("out_data", out_data, m_word);
            end
        end
    end

    task automatic send_req(input logic [2:0] a, input logic [2:0] l);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 3'($urandom);
        req_len   = 3'($urandom);
    endtask

    task automatic wait_done();
        int t = 0;
        while (t < 64) begin
            if (out_valid && out_ready && out_last) break;
            @(negedge clk);
            t++;
        end
        if (t >= 64) begin
            checks++;
            errors++;
            $display("FAIL burst_timeout: no final handshake within 64 cycles at %0t", $time);
        end
        @(posedge clk);
    endtask

    initial begin
        automatic int exp_idx [4] = '{6, 7, 0, 1};
        for (int i = 0; i < 8; i++) regs[i] = {32'hC0DE_0000 | 32'(i), $urandom};
        regs[2] = 64'hDEAD_BEEF_0000_0002;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  out_data, 64'd0);
        chk("rst_out_idx",   64'(out_idx), 64'd0);
        chk("rst_out_last",  64'(out_last), 64'd0);
        chk("rst_burst_cnt", 64'(burst_cnt), 64'd0);
        rst = 1'b0;

        // Single-word burst at register 2
        seen.delete();
        send_req(3'd2, 3'd0);
        wait_done();
        @(negedge clk);
        chk("t1_count", 64'(seen.size()), 64'd1);
        if (seen.size() == 1) begin
            chk("t1_idx",  64'(seen[0].idx), 64'd2);
            chk("t1_data", seen[0].data, 64'hDEAD_BEEF_0000_0002);
            chk("t1_last", 64'(seen[0].last), 64'd1);
        end
        chk("t1_burst_cnt", 64'(burst_cnt), 64'd1);

        // Wrapping 4-word burst
        seen.delete();
        send_req(3'd6, 3'd3);
        wait_done();
        @(negedge clk);
        chk("t2_count", 64'(seen.size()), 64'd4);
        for (int k = 0; k < 4 && k < seen.size(); k++) begin
            chk("t2_idx",  64'(seen[k].idx), 64'(exp_idx[k]));
            chk("t2_data", seen[k].data, regs[exp_idx[k]]);
            chk("t2_last", 64'(seen[k].last), 64'(k == 3));
        end

        // Same burst, consumer stalls 3 cycles on the second word
        seen.delete();
        send_req(3'd6, 3'd3);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t3_hold_idx",  64'(out_idx), 64'd7);
            chk("t3_hold_data", out_data, regs[7]);
        end
        out_ready = 1'b1;
        wait_done();
        @(negedge clk);
        chk("t3_count", 64'(seen.size()), 64'd4);
        for (int k = 0; k < 4 && k < seen.size(); k++)
            chk("t3_idx", 64'(seen[k].idx), 64'(exp_idx[k]));
        chk("t3_burst_cnt", 64'(burst_cnt), 64'd3);

        // Register 3 rewritten while word 2 of a burst from index 1 is presented
        regs[3] = 64'h1;
        seen.delete();
        send_req(3'd1, 3'd3);
        @(negedge clk);
        chk("t4_pres_idx", 64'(out_idx), 64'd2);
        regs[3] = 64'h2;
        wait_done();
        @(negedge clk);
        chk("t4_count", 64'(seen.size()), 64'd4);
        if (seen.size() == 4) begin
            chk("t4_idx3", 64'(seen[2].idx), 64'd3);
            chk("t4_word3", seen[2].data, SNAP ? 64'h1 : 64'h2);
        end

        // Asynchronous reset in the middle of an 8-word burst
        send_req(3'd0, 3'd7);
        @(negedge clk);
        chk("t5_pres_idx", 64'(out_idx), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_req_ready", 64'(req_ready), 64'd1);
        chk("t5_out_data",  out_data, 64'd0);
        chk("t5_out_last",  64'(out_last), 64'd0);
        chk("t5_burst_cnt", 64'(burst_cnt), 64'd0);
        #1 rst = 1'b0;
        seen.delete();
        send_req(3'd5, 3'd1);
        wait_done();
        @(negedge clk);
        chk("t5_count", 64'(seen.size()), 64'd2);
        if (seen.size() == 2) begin
            chk("t5_idx0", 64'(seen[0].idx), 64'd5);
            chk("t5_idx1", 64'(seen[1].idx), 64'd6);
        end
        chk("t5_after_cnt", 64'(burst_cnt), 64'd1);

        // Counter saturation, pre-loaded close to the top
        @(negedge clk);
        #2;
        force dut.r_burst_cnt = 16'hFFFC;
        m_cnt = 16'hFFFC;
        #1 release dut.r_burst_cnt;
        for (int b = 0; b < 5; b++) begin
            send_req(3'(b), 3'd0);
            wait_done();
        end
        @(negedge clk);
        chk("t6_saturated", 64'(burst_cnt), 64'hFFFF);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
